// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: synchronizer chain, per-channel debounce,
// registered rise/fall/edge pulses and sticky event flags with per-channel clear.
module input_conditioner #(
    parameter int N          = 4,
    parameter int STAGES     = 3,
    parameter int DEB_CYCLES = 16,
    parameter int EDGE_MODE  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic [N-1:0] clear,
    output logic [N-1:0] level_out,
    output logic [N-1:0] rise_out,
    output logic [N-1:0] fall_out,
    output logic [N-1:0] edge_out,
    output logic [N-1:0] flags,
    output logic         irq
);

    localparam int CW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [N-1:0] w_sync;
    logic [N-1:0] w_level;
    logic [N-1:0] w_rise_next;
    logic [N-1:0] w_fall_next;
    logic [N-1:0] w_edge_next;

    logic [N-1:0] r_level_prev;
    logic [N-1:0] r_rise;
    logic [N-1:0] r_fall;
    logic [N-1:0] r_edge;
    logic [N-1:0] r_flags;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic [STAGES-1:0] r_sync;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], data_in[gi]};
                end
            end

            assign w_sync[gi] = r_sync[STAGES-1];

            if (DEB_CYCLES > 0) begin : g_deb
                localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
                logic [CW-1:0] r_count;
                logic          r_level;

                // Level is accepted only after DEB_CYCLES consecutive deviating samples.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_count <= '0;
                        r_level <= 1'b0;
                    end else if (w_sync[gi] == r_level) begin
                        r_count <= '0;
                    end else if (r_count == LAST) begin
                        r_level <= w_sync[gi];
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end

                assign w_level[gi] = r_level;
            end else begin : g_bypass
                logic r_level;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_level <= 1'b0;
                    end else begin
                        r_level <= w_sync[gi];
                    end
                end

                assign w_level[gi] = r_level;
            end
        end

        if (EDGE_MODE == 0) begin : g_edge_rise
            assign w_edge_next = w_rise_next;
        end else if (EDGE_MODE == 1) begin : g_edge_fall
            assign w_edge_next = w_fall_next;
        end else begin : g_edge_both
            assign w_edge_next = w_rise_next | w_fall_next;
        end
    endgenerate

    assign w_rise_next = w_level & ~r_level_prev;
    assign w_fall_next = ~w_level & r_level_prev;

    // Flags use the pulse being registered this edge, so set beats a same-edge clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_prev <= '0;
            r_rise       <= '0;
            r_fall       <= '0;
            r_edge       <= '0;
            r_flags      <= '0;
        end else begin
            r_level_prev <= w_level;
            r_rise       <= w_rise_next;
            r_fall       <= w_fall_next;
            r_edge       <= w_edge_next;
            r_flags      <= w_edge_next | (r_flags & ~clear);
        end
    end

    assign level_out = w_level;
    assign rise_out  = r_rise;
    assign fall_out  = r_fall;
    assign edge_out  = r_edge;
    assign flags     = r_flags;
    assign irq       = |r_flags;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: expectations are queued with their due
// cycle as stimulus is driven and compared by a negedge monitor.
module tb_input_conditioner;

    localparam int L0 = 0,  R0 = 1,  F0 = 2,  E0 = 3,  G0 = 4,  I0 = 5;
    localparam int L1 = 6,  R1 = 7,  F1 = 8,  E1 = 9,  G1 = 10, I1 = 11;
    localparam int L2 = 12, R2 = 13, F2 = 14, E2 = 15, G2 = 16, I2 = 17;

    typedef struct {
        int         at;
        int         sel;
        logic [3:0] v;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] d0, d1, d2;
    logic [3:0] c0, c1, c2;

    logic [3:0] lvl0, rise0, fall0, edg0, flg0;
    logic [3:0] lvl1, rise1, fall1, edg1, flg1;
    logic [3:0] lvl2, rise2, fall2, edg2, flg2;
    logic       irq0, irq1, irq2;

    int         cyc;
    int         n_cmp;
    int         n_fail;
    exp_t       sb[$];
    logic [3:0] mon_obs;

    input_conditioner #(.N(4), .STAGES(3), .DEB_CYCLES(4), .EDGE_MODE(2)) u_main (
        .clk(clk), .rst(rst), .data_in(d0), .clear(c0),
        .level_out(lvl0), .rise_out(rise0), .fall_out(fall0),
        .edge_out(edg0), .flags(flg0), .irq(irq0)
    );

    input_conditioner #(.N(4), .STAGES(3), .DEB_CYCLES(4), .EDGE_MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .data_in(d1), .clear(c1),
        .level_out(lvl1), .rise_out(rise1), .fall_out(fall1),
        .edge_out(edg1), .flags(flg1), .irq(irq1)
    );

    input_conditioner #(.N(4), .STAGES(3), .DEB_CYCLES(0), .EDGE_MODE(2)) u_d0 (
        .clk(clk), .rst(rst), .data_in(d2), .clear(c2),
        .level_out(lvl2), .rise_out(rise2), .fall_out(fall2),
        .edge_out(edg2), .flags(flg2), .irq(irq2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] observe(int sel);
        case (sel)
            L0: return lvl0;
            R0: return rise0;
            F0: return fall0;
            E0: return edg0;
            G0: return flg0;
            I0: return {3'b000, irq0};
            L1: return lvl1;
            R1: return rise1;
            F1: return fall1;
            E1: return edg1;
            G1: return flg1;
            I1: return {3'b000, irq1};
            L2: return lvl2;
            R2: return rise2;
            F2: return fall2;
            E2: return edg2;
            G2: return flg2;
            I2: return {3'b000, irq2};
            default: return 4'bxxxx;
        endcase
    endfunction

    task automatic exp_at(input int k, input int sel, input logic [3:0] v, input string tag);
        exp_t e;
        e.at  = cyc + k;
        e.sel = sel;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
    end

    // Scoreboard monitor: compare every expectation due on this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                mon_obs = observe(sb[i].sel);
                n_cmp++;
                assert (mon_obs === sb[i].v && sb[i].at == cyc) else begin
                    n_fail++;
                    $error("FAIL %s @cyc %0d: observed %h expected %h", sb[i].tag, cyc, mon_obs, sb[i].v);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        // Reset with all inputs high, then idle
        rst = 1'b1; d0 = 4'hF; d1 = 4'hF; d2 = 4'hF;
        c0 = 4'h0; c1 = 4'h0; c2 = 4'h0;
        step(3);
        exp_at(0, L0, 4'h0, "rst_level");
        exp_at(0, R0, 4'h0, "rst_rise");
        exp_at(0, F0, 4'h0, "rst_fall");
        exp_at(0, E0, 4'h0, "rst_edge");
        exp_at(0, G0, 4'h0, "rst_flags");
        exp_at(0, I0, 4'h0, "rst_irq");
        exp_at(0, L1, 4'h0, "rst_m0_level");
        exp_at(0, L2, 4'h0, "rst_d0_level");
        rst = 1'b0; d0 = 4'h0; d1 = 4'h0; d2 = 4'h0;
        for (int k = 1; k <= 20; k++) begin
            exp_at(k, L0, 4'h0, "idle_level");
            exp_at(k, G0, 4'h0, "idle_flags");
            exp_at(k, E0, 4'h0, "idle_edge");
        end
        exp_at(20, I0, 4'h0, "idle_irq");
        exp_at(20, G1, 4'h0, "idle_m0_flags");
        exp_at(20, G2, 4'h0, "idle_d0_flags");
        step(20);

        // Clean rise on ch0 (main, bypass) and ch3 (rising-only instance)
        d0 = 4'h1; d1 = 4'h8; d2 = 4'h1;
        exp_at(6, L0, 4'h0, "rise_level_early");
        exp_at(7, L0, 4'h1, "rise_level");
        exp_at(7, R0, 4'h0, "rise_pulse_early");
        exp_at(8, R0, 4'h1, "rise_pulse");
        exp_at(9, R0, 4'h0, "rise_pulse_end");
        exp_at(8, E0, 4'h1, "rise_edge");
        exp_at(9, E0, 4'h0, "rise_edge_end");
        exp_at(8, F0, 4'h0, "rise_no_fall");
        exp_at(7, G0, 4'h0, "rise_flags_early");
        exp_at(8, G0, 4'h1, "rise_flags");
        exp_at(7, I0, 4'h0, "rise_irq_early");
        exp_at(8, I0, 4'h1, "rise_irq");
        exp_at(3, L2, 4'h0, "d0_level_early");
        exp_at(4, L2, 4'h1, "d0_level");
        exp_at(5, R2, 4'h1, "d0_rise");
        exp_at(8, R1, 4'h8, "m0_rise");
        exp_at(8, E1, 4'h8, "m0_rise_edge");
        exp_at(8, G1, 4'h8, "m0_rise_flags");
        step(12);

        // 3-cycle glitch on ch1 is rejected; clear the rising-only flag meanwhile
        c1 = 4'h8; d0 = 4'h3;
        exp_at(0, G1, 4'h8, "m0_flags_before_clr");
        exp_at(1, G1, 4'h0, "m0_flags_cleared");
        exp_at(1, I1, 4'h0, "m0_irq_cleared");
        for (int k = 1; k <= 14; k++) begin
            exp_at(k, L0, 4'h1, "glitch_level");
            exp_at(k, R0, 4'h0, "glitch_rise");
            exp_at(k, F0, 4'h0, "glitch_fall");
        end
        step(1);
        c1 = 4'h0;
        step(2);
        d0 = 4'h1;
        step(12);

        // 4-cycle pulse on ch1 is accepted for exactly 4 cycles
        d0 = 4'h3;
        exp_at(6, L0, 4'h1, "pulse_level_early");
        for (int k = 7; k <= 10; k++) exp_at(k, L0, 4'h3, "pulse_level");
        exp_at(11, L0, 4'h1, "pulse_level_end");
        exp_at(8, R0, 4'h2, "pulse_rise");
        exp_at(9, R0, 4'h0, "pulse_rise_end");
        exp_at(11, F0, 4'h0, "pulse_fall_early");
        exp_at(12, F0, 4'h2, "pulse_fall");
        exp_at(13, F0, 4'h0, "pulse_fall_end");
        exp_at(8, G0, 4'h3, "pulse_flags");
        step(4);
        d0 = 4'h1;
        step(14);

        // Flag clear: clear during set loses, clear alone wins
        d0 = 4'h0; c0 = 4'h3; d1 = 4'h0; d2 = 4'h0;
        exp_at(1, G0, 4'h0, "clr_flags");
        exp_at(1, I0, 4'h0, "clr_irq");
        exp_at(6, L0, 4'h1, "fall_level_early");
        exp_at(7, L0, 4'h0, "fall_level");
        exp_at(8, F0, 4'h1, "fall_pulse");
        exp_at(8, E0, 4'h1, "fall_edge");
        exp_at(8, G0, 4'h1, "set_beats_clear");
        exp_at(8, I0, 4'h1, "set_beats_clear_irq");
        exp_at(9, G0, 4'h0, "clear_alone");
        exp_at(9, I0, 4'h0, "clear_alone_irq");
        exp_at(6, L1, 4'h8, "m0_level_early");
        exp_at(7, L1, 4'h0, "m0_level_fall");
        exp_at(8, F1, 4'h8, "m0_fall");
        exp_at(8, R1, 4'h0, "m0_no_rise");
        exp_at(8, E1, 4'h0, "m0_fall_no_edge");
        exp_at(8, G1, 4'h0, "m0_fall_no_flag");
        exp_at(9, G1, 4'h0, "m0_fall_no_flag_late");
        exp_at(3, L2, 4'h1, "d0_fall_early");
        exp_at(4, L2, 4'h0, "d0_fall_level");
        exp_at(5, F2, 4'h1, "d0_fall");
        exp_at(5, E2, 4'h1, "d0_fall_edge");
        exp_at(5, G2, 4'h1, "d0_flags");
        step(1);
        c0 = 4'h0;
        step(6);
        c0 = 4'h1;
        step(1);
        step(1);
        c0 = 4'h0;
        step(4);

        // Reset mid-count on ch2 discards progress
        d0 = 4'h4;
        exp_at(4, L0, 4'h0, "midrst_level_pre");
        exp_at(5, L0, 4'h0, "midrst_level");
        exp_at(5, G2, 4'h0, "midrst_d0_flags");
        exp_at(5, I2, 4'h0, "midrst_d0_irq");
        exp_at(7, L0, 4'h0, "midrst_level_orig_due");
        exp_at(11, L0, 4'h0, "midrst_level_early");
        exp_at(12, L0, 4'h4, "midrst_level_after");
        exp_at(12, R0, 4'h0, "midrst_rise_early");
        exp_at(13, R0, 4'h4, "midrst_rise");
        exp_at(13, E0, 4'h4, "midrst_edge");
        exp_at(13, G0, 4'h4, "midrst_flags");
        exp_at(13, I0, 4'h1, "midrst_irq");
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(12);

        step(2);
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel input conditioner. It takes N asynchronous, slow-changing inputs (buttons, switches, external strobes) into the `clk` domain through a configurable-depth synchronizer chain, debounces each channel with a per-channel stability counter, and produces clean levels, single-cycle rise/fall pulses, and sticky event flags with per-channel clear. It sits between the board pins and the game/control logic, and replaces ad-hoc synchronizer-plus-edge-detector pairs.

## Interface
- `N`, default 4: number of independent channels.
- `STAGES`, default 3: synchronizer flip-flops per channel; legal range ≥ 2.
- `DEB_CYCLES`, default 16: consecutive cycles a changed synced value must persist before the level is accepted. 0 = bypass.
- `EDGE_MODE`, default 2: which edges set flags and `edge_out`. 0 = rising only, 1 = falling only, 2 = both.
- `clk` input 1: single clock, all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_in` input N: asynchronous raw inputs.
- `clear` input N: per-channel sticky-flag clear, synchronous, level-sensitive.
- `level_out` output N: debounced stable level.
- `rise_out` output N: one-cycle pulse per accepted 0→1 transition.
- `fall_out` output N: one-cycle pulse per accepted 1→0 transition.
- `edge_out` output N: `rise_out` and/or `fall_out`, selected by `EDGE_MODE`.
- `flags` output N: sticky event flags.
- `irq` output 1: OR-reduction of `flags`; combinational from registers.

## Operation
- Synchronizer: per channel, `STAGES` registers in series. The synced value `s` is the last stage.
- Debouncer (`DEB_CYCLES` = D > 0): holds the accepted level `L` and a counter of width clog2(D+1).
  - On an edge where `s == L`: counter ← 0.
  - On an edge where `s != L` and counter == D−1: `L` ← `s`, counter ← 0.
  - On an edge where `s != L` otherwise: counter ← counter + 1.
  - A deviation shorter than D consecutive synced cycles never changes `L`.
- Bypass (D = 0): `L` ← `s` every cycle. D = 1 behaves identically.
- `level_out` = `L`.
- Edge pulses are registered: `rise_out` ← `L & ~L_prev`, `fall_out` ← `~L & L_prev`. `L_prev` is `L` delayed one cycle.
- `edge_out` is selected from `rise_out`/`fall_out` by `EDGE_MODE`. The value 3 is treated as 2.
- Flags, per channel, each edge:
  - `edge_out[i]` = 1: flag ← 1. Set wins over a simultaneous `clear[i]`, so no event is lost.
  - Else `clear[i]` = 1: flag ← 0.
  - Otherwise: hold.
- Channels are fully independent. There is no cross-channel arbitration.
- Reset:
  - While `rst` is sampled high, every register clears to 0: sync stages, `L`, `L_prev`, counters, pulses, flags.
  - All outputs read 0 the cycle after that edge.
  - A reset mid-count discards progress. After release the full D cycles are required again.
  - An input already high at reset release produces a normal rise after the full latency. This is intentional.

## Timing
- Reference point: `data_in[i]` changes between edge 0 and edge 1.
- `s` reflects the change after edge `STAGES`.
- `level_out` changes after edge `STAGES + max(D,1)`.
- `rise_out`/`fall_out`/`edge_out` are high for exactly the one cycle following edge `STAGES + max(D,1) + 1`.
- `flags` sets on that same edge. `irq` follows in the same cycle.
- `clear` takes effect on the next edge; the flag reads 0 one cycle later.
- Minimum accepted pulse width on `data_in`: D cycles, assuming a metastability-free capture. Back-to-back transitions are spaced ≥ D cycles apart at `level_out`.

## Test plan
All scenarios use N=4, STAGES=3, D=4, EDGE_MODE=2 unless noted.
- **Reset:** `rst`=1 for 3 cycles with `data_in`=4'hF → all outputs 0. Release with `data_in`=0 → outputs stay 0 for 20 cycles.
- **Clean rise:** `data_in[0]` 0→1 before edge 1 → `level_out[0]`=1 after edge 7; `rise_out[0]` and `edge_out[0]` high only after edge 8; `flags[0]`=1 and `irq`=1 after edge 8; channels 1–3 unchanged.
- **Glitch filter:**
  - `data_in[1]` high for 3 cycles → no change on any output; counter back at 0.
  - Repeat with 4 cycles → `level_out[1]` high for exactly 4 cycles; one rise pulse and one fall pulse, spaced 4 cycles apart.
- **Flag clear:**
  - `clear[0]` asserted on the same edge as an `edge_out[0]` pulse → `flags[0]` stays 1.
  - `clear[0]` alone one cycle later → `flags[0]`=0; `irq`=0.
- **Reset mid-count:** `rst` pulsed at edge 5 during a ch2 rise → `level_out[2]` stays 0. After release, the rise appears 7 edges later.
- **Modes:**
  - EDGE_MODE=0 instance, ch3 does 1→0 → `fall_out[3]` pulses; `edge_out[3]` and `flags[3]` stay 0.
  - D=0 instance → `level_out` follows after edge 4.
